cam_frame_writer: RTL and testbench
===================================

CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, meaning per-bank address width, with H_ACTIVE*V_ACTIVE <= 2^ADDR_W.
REQ-004 SHALL have port i_pclk, input, 1 bit: pixel clock, single clock domain, posedge only.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_capture_en, input, 1 bit: arm capture; sampled only in IDLE.
REQ-007 SHALL have port i_vsync, input, 1 bit: camera VSYNC, high = vertical blanking.
REQ-008 SHALL have port i_href, input, 1 bit: camera HREF, high = active line.
REQ-009 SHALL have port i_pixel, input, 16 bits: RGB565 pixel from capture stage.
REQ-010 SHALL have port i_pixel_en, input, 1 bit: i_pixel valid this cycle.
REQ-011 SHALL have port o_wr_en, output, 1 bit: frame-buffer write strobe.
REQ-012 SHALL have port o_wr_addr, output, ADDR_W+1 bits: {write bank, linear pixel index}.
REQ-013 SHALL have port o_wr_data, output, 16 bits: pixel to write.
REQ-014 SHALL have port o_rd_bank, output, 1 bit: bank holding last complete frame, for display side.
REQ-015 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse on good frame completion.
REQ-016 SHALL have port o_frame_err, output, 1 bit: sticky error for current/last frame.

Function
REQ-017 SHALL register i_vsync and i_href once (vs_q, hr_q) for edge detect; rise = in & ~q, fall = ~in & q.
REQ-018 SHALL implement FSM IDLE, SYNC, ACTIVE.
REQ-019 IDLE: go SYNC when i_capture_en=1.
REQ-020 SYNC: wait for vsync fall; on fall go ACTIVE, clear x, y, linear index and o_frame_err.
REQ-021 ACTIVE: on vsync rise, end frame; go SYNC if i_capture_en=1, else IDLE.
REQ-022 SHALL accept a pixel only in ACTIVE with i_pixel_en=1, x<H_ACTIVE and y<V_ACTIVE.
REQ-023 On accept: o_wr_en=1 next cycle, o_wr_data=i_pixel, o_wr_addr={wr_bank, index}; then index+1, x+1 (latency 1 cycle).
REQ-024 SHALL keep index as a running counter; no multiplier.
REQ-025 Pixel with i_pixel_en=1 but x>=H_ACTIVE or y>=V_ACTIVE: no write, set o_frame_err.
REQ-026 On href fall in ACTIVE: set o_frame_err if x!=H_ACTIVE; then x=0, y+1 (y saturates at V_ACTIVE).
REQ-027 href fall and accepted pixel in the same cycle: write that pixel first, then evaluate x including it.
REQ-028 Frame end, if index==H_ACTIVE*V_ACTIVE and no error: o_rd_bank<=wr_bank, toggle wr_bank, pulse o_frame_done.
REQ-029 Frame end, otherwise: set o_frame_err, no bank swap, no o_frame_done.
REQ-030 o_frame_err SHALL hold until the next vsync fall in SYNC.
REQ-031 i_capture_en deassert during ACTIVE SHALL NOT abort the current frame.
REQ-032 o_wr_en SHALL be 0 in every cycle with no accepted pixel; o_wr_addr and o_wr_data hold last values.

Reset
REQ-033 i_rst_n=0 SHALL asynchronously set: state IDLE; x, y, index 0; wr_bank 0; o_rd_bank 1; o_wr_en 0; o_wr_addr 0; o_wr_data 0; o_frame_done 0; o_frame_err 0; vs_q 1; hr_q 0.
REQ-034 Reset mid-frame SHALL discard the partial frame; after release, capture waits for a fresh vsync fall.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-035 Good frame: capture_en=1, vsync 1->0, two href lines of 4 pixels 0x0001..0x0008, vsync rise -> writes addr 0..7 data 0x0001..0x0008 bank 0; o_frame_done one pulse; o_rd_bank=0; next frame writes bank 1.
REQ-036 Short line: second line has 3 pixels -> o_frame_err=1 at href fall; no o_frame_done; o_rd_bank stays 1; wr_bank stays 0.
REQ-037 Overlong frame: third href line of 4 pixels -> no writes for it, o_frame_err=1, no swap.
REQ-038 Mid-frame reset after 3 writes -> all outputs at reset values; vsync low on release gives no writes until the next vsync fall.
REQ-039 capture_en drops during ACTIVE -> frame completes with o_frame_done, FSM returns to IDLE, next frame is ignored.
REQ-040 Pixel on the href-fall cycle as 4th pixel -> write occurs, no error.

Source files
------------

// File: rtl/cam_frame_writer.sv
// Camera frame writer: places RGB565 pixels into a double-buffered frame store
// and hands the completed bank to the display side after each good frame.
module cam_frame_writer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              i_pclk,
   input  logic              i_rst_n,
   input  logic              i_capture_en,
   input  logic              i_vsync,
   input  logic              i_href,
   input  logic [15:0]       i_pixel,
   input  logic              i_pixel_en,
   output logic              o_wr_en,
   output logic [ADDR_W:0]   o_wr_addr,
   output logic [15:0]       o_wr_data,
   output logic              o_rd_bank,
   output logic              o_frame_done,
   output logic              o_frame_err
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   // One extra bit so a full frame count still fits when H*V == 2^ADDR_W.
   localparam int IW = ADDR_W + 1;
   localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);
   localparam logic [IW-1:0] TOTAL = IW'(H_ACTIVE * V_ACTIVE);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

   state_t        state;
   logic          vs_q, hr_q;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [IW-1:0] idx;
   logic          wr_bank;

   logic          vs_rise, vs_fall, hr_fall, in_active, in_window;
   logic          pix_ok, pix_bad, line_bad, err_now, frame_good;
   logic [XW-1:0] x_inc;
   logic [IW-1:0] idx_inc;

   always_comb begin
      vs_rise    = i_vsync & ~vs_q;
      vs_fall    = ~i_vsync & vs_q;
      hr_fall    = ~i_href & hr_q;
      in_active  = (state == ACTIVE);
      in_window  = (x < X_MAX) && (y < Y_MAX);
      pix_ok     = in_active & i_pixel_en & in_window;
      pix_bad    = in_active & i_pixel_en & ~in_window;
      // A pixel landing on the href-fall cycle counts toward that line's length.
      x_inc      = pix_ok ? x + 1'b1 : x;
      idx_inc    = pix_ok ? idx + 1'b1 : idx;
      line_bad   = in_active & hr_fall & (x_inc != X_MAX);
      err_now    = o_frame_err | pix_bad | line_bad;
      frame_good = (idx_inc == TOTAL) & ~err_now;
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         vs_q         <= 1'b1;
         hr_q         <= 1'b0;
         x            <= '0;
         y            <= '0;
         idx          <= '0;
         wr_bank      <= 1'b0;
         o_rd_bank    <= 1'b1;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         vs_q         <= i_vsync;
         hr_q         <= i_href;
         o_wr_en      <= 1'b0;
         o_frame_done <= 1'b0;

         if (pix_ok) begin
            o_wr_en   <= 1'b1;
            o_wr_data <= i_pixel;
            o_wr_addr <= {wr_bank, idx[ADDR_W-1:0]};
         end

         case (state)
            IDLE: begin
               if (i_capture_en) state <= SYNC;
            end
            SYNC: begin
               if (vs_fall) begin
                  state       <= ACTIVE;
                  x           <= '0;
                  y           <= '0;
                  idx         <= '0;
                  o_frame_err <= 1'b0;
               end
            end
            ACTIVE: begin
               x           <= x_inc;
               idx         <= idx_inc;
               o_frame_err <= err_now;
               if (hr_fall) begin
                  x <= '0;
                  if (y != Y_MAX) y <= y + 1'b1;
               end
               // Capture enable only decides where we go after the frame ends.
               if (vs_rise) begin
                  if (frame_good) begin
                     o_rd_bank    <= wr_bank;
                     wr_bank      <= ~wr_bank;
                     o_frame_done <= 1'b1;
                  end else begin
                     o_frame_err  <= 1'b1;
                  end
                  state <= i_capture_en ? SYNC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer at a 4x2 frame: expected writes are
// queued by the stimulus and matched by an independent output monitor.
module tb_cam_frame_writer;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 3;

   logic          pclk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cap = 1'b0;
   logic          vs = 1'b1;
   logic          hr = 1'b0;
   logic          pen = 1'b0;
   logic [15:0]   pix = '0;
   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [15:0]   wr_data;
   logic          rd_bank;
   logic          frame_done;
   logic          frame_err;

   cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .i_pclk       (pclk),
      .i_rst_n      (rst_n),
      .i_capture_en (cap),
      .i_vsync      (vs),
      .i_href       (hr),
      .i_pixel      (pix),
      .i_pixel_en   (pen),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_rd_bank    (rd_bank),
      .o_frame_done (frame_done),
      .o_frame_err  (frame_err)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [AW:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  vectors = 0;
   int  miscompares = 0;
   int  done_cnt = 0;

   always @(negedge pclk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (wr_en === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
               miscompares++;
               $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        wr_addr, wr_data, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic h, input logic pe, input logic [15:0] p);
      vs = v; hr = h; pen = pe; pix = p;
      @(posedge pclk);
      #1;
   endtask

   task automatic push(input int a, input logic [15:0] d);
      wr_t w;
      w.addr = (AW+1)'(a);
      w.data = d;
      exp_q.push_back(w);
   endtask

   // n_hi pixels with href high; optionally one more pixel on the href-fall cycle.
   task automatic line(input int n_hi, input bit last_on_fall, input logic [15:0] p0,
                       input int a0, input bit wr_exp);
      for (int k = 0; k < n_hi; k++) begin
         if (wr_exp) push(a0 + k, p0 + 16'(k));
         cyc(1'b0, 1'b1, 1'b1, p0 + 16'(k));
      end
      if (last_on_fall) begin
         if (wr_exp) push(a0 + n_hi, p0 + 16'(n_hi));
         cyc(1'b0, 1'b0, 1'b1, p0 + 16'(n_hi));
      end else begin
         cyc(1'b0, 1'b0, 1'b0, 16'h0);
      end
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic frame_start();
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic frame_end();
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
      chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
      chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
      chk({tag, "_rd_bank"},    32'(rd_bank),    32'd1);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset_vals("reset");
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      #1;
      do_reset();

      // good frame into bank 0, then next frame into bank 1
      cap = 1'b1;
      frame_start();
      line(4, 1'b0, 16'h0001, 0, 1'b1);
      line(4, 1'b0, 16'h0005, 4, 1'b1);
      frame_end();
      chk("good1_done_cnt", 32'(done_cnt), 32'd1);
      chk("good1_rd_bank", 32'(rd_bank), 32'd0);
      chk("good1_err", 32'(frame_err), 32'd0);
      chk("good1_q_empty", 32'(exp_q.size()), 32'd0);
      frame_start();
      line(4, 1'b0, 16'h0011, 8, 1'b1);
      line(4, 1'b0, 16'h0015, 12, 1'b1);
      frame_end();
      chk("good2_done_cnt", 32'(done_cnt), 32'd2);
      chk("good2_rd_bank", 32'(rd_bank), 32'd1);

      // short second line: error, no swap; following good frame still in bank 0
      frame_start();
      line(4, 1'b0, 16'h0021, 0, 1'b1);
      line(3, 1'b0, 16'h0025, 4, 1'b1);
      chk("short_err_at_fall", 32'(frame_err), 32'd1);
      frame_end();
      chk("short_done_cnt", 32'(done_cnt), 32'd2);
      chk("short_rd_bank", 32'(rd_bank), 32'd1);
      chk("short_err_sticky", 32'(frame_err), 32'd1);
      frame_start();
      chk("err_clear_on_fall", 32'(frame_err), 32'd0);
      line(4, 1'b0, 16'h0031, 0, 1'b1);
      line(4, 1'b0, 16'h0035, 4, 1'b1);
      frame_end();
      chk("recover_done_cnt", 32'(done_cnt), 32'd3);
      chk("recover_rd_bank", 32'(rd_bank), 32'd0);

      // overlong frame: third line dropped, error, no swap
      frame_start();
      line(4, 1'b0, 16'h0041, 8, 1'b1);
      line(4, 1'b0, 16'h0045, 12, 1'b1);
      line(4, 1'b0, 16'h0049, 0, 1'b0);
      chk("overlong_err", 32'(frame_err), 32'd1);
      frame_end();
      chk("overlong_done_cnt", 32'(done_cnt), 32'd3);
      chk("overlong_rd_bank", 32'(rd_bank), 32'd0);
      chk("overlong_q_empty", 32'(exp_q.size()), 32'd0);

      // mid-frame reset after three writes
      do_reset();
      frame_start();
      push(0, 16'h0051); cyc(1'b0, 1'b1, 1'b1, 16'h0051);
      push(1, 16'h0052); cyc(1'b0, 1'b1, 1'b1, 16'h0052);
      push(2, 16'h0053); cyc(1'b0, 1'b1, 1'b1, 16'h0053);
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      chk("midreset_q_empty", 32'(exp_q.size()), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      line(4, 1'b0, 16'h0061, 0, 1'b0);
      line(4, 1'b0, 16'h0065, 4, 1'b0);
      chk("postreset_done_cnt", 32'(done_cnt), 32'd3);
      chk("postreset_err", 32'(frame_err), 32'd0);
      frame_start();
      line(4, 1'b0, 16'h0071, 0, 1'b1);
      line(4, 1'b0, 16'h0075, 4, 1'b1);
      frame_end();
      chk("postreset_good_done", 32'(done_cnt), 32'd4);
      chk("postreset_rd_bank", 32'(rd_bank), 32'd0);

      // capture_en drops mid-frame: frame completes, next frame ignored
      frame_start();
      cap = 1'b0;
      line(4, 1'b0, 16'h0081, 8, 1'b1);
      line(4, 1'b0, 16'h0085, 12, 1'b1);
      frame_end();
      chk("capdrop_done_cnt", 32'(done_cnt), 32'd5);
      chk("capdrop_rd_bank", 32'(rd_bank), 32'd1);
      frame_start();
      line(4, 1'b0, 16'h0091, 0, 1'b0);
      line(4, 1'b0, 16'h0095, 4, 1'b0);
      frame_end();
      chk("ignored_done_cnt", 32'(done_cnt), 32'd5);
      chk("ignored_rd_bank", 32'(rd_bank), 32'd1);
      chk("ignored_q_empty", 32'(exp_q.size()), 32'd0);

      // 4th pixel on the href-fall cycle of each line
      cap = 1'b1;
      frame_start();
      line(3, 1'b1, 16'h00A1, 0, 1'b1);
      line(3, 1'b1, 16'h00A5, 4, 1'b1);
      chk("fallpix_err", 32'(frame_err), 32'd0);
      frame_end();
      chk("fallpix_done_cnt", 32'(done_cnt), 32'd6);
      chk("fallpix_rd_bank", 32'(rd_bank), 32'd0);
      chk("fallpix_err_end", 32'(frame_err), 32'd0);
      chk("fallpix_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
